// File: rtl/id_exe_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush
// control and saturating stall/flush performance counters.
module id_exe_hazard_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_stall,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              exe_branch_taken,
    output logic              exe_valid,
    output logic [XLEN-1:0]   exe_pc,
    output logic [XLEN-1:0]   exe_rs1_data,
    output logic [XLEN-1:0]   exe_rs2_data,
    output logic [XLEN-1:0]   exe_imm,
    output logic [4:0]        exe_rs1_addr,
    output logic [4:0]        exe_rs2_addr,
    output logic [4:0]        exe_rd_addr,
    output logic              exe_regWrite,
    output logic              exe_memRead,
    output logic              exe_memWrite,
    output logic [CTRL_W-1:0] exe_ctrl,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              load_use,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Per-cycle action chosen by priority: hold > flush > stall > capture
    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_HOLD,
        ACT_FLUSH,
        ACT_STALL
    } action_t;

    action_t action;
    logic    flush;
    logic    rs1_hit;
    logic    rs2_hit;

    // Hazard detection and pipeline-control decode
    always_comb begin
        rs1_hit    = id_uses_rs1 && (id_rs1_addr == exe_rd_addr);
        rs2_hit    = id_uses_rs2 && (id_rs2_addr == exe_rd_addr);
        load_use   = id_valid && exe_valid && exe_memRead &&
                     (exe_rd_addr != 5'd0) && (rs1_hit || rs2_hit);
        flush      = exe_valid && exe_branch_taken;
        action     = ACT_CAPTURE;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        if (mem_stall) begin
            action     = ACT_HOLD;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (flush) begin
            action     = ACT_FLUSH;
            ifid_flush = 1'b1;
        end else if (load_use) begin
            action     = ACT_STALL;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    // ID/EX register: hold, load a bubble, or capture the ID instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid    <= 1'b0;
            exe_pc       <= '0;
            exe_rs1_data <= '0;
            exe_rs2_data <= '0;
            exe_imm      <= '0;
            exe_rs1_addr <= '0;
            exe_rs2_addr <= '0;
            exe_rd_addr  <= '0;
            exe_regWrite <= 1'b0;
            exe_memRead  <= 1'b0;
            exe_memWrite <= 1'b0;
            exe_ctrl     <= '0;
        end else begin
            case (action)
                ACT_HOLD: ;
                ACT_FLUSH, ACT_STALL: begin
                    exe_valid    <= 1'b0;
                    exe_pc       <= '0;
                    exe_rs1_data <= '0;
                    exe_rs2_data <= '0;
                    exe_imm      <= '0;
                    exe_rs1_addr <= '0;
                    exe_rs2_addr <= '0;
                    exe_rd_addr  <= '0;
                    exe_regWrite <= 1'b0;
                    exe_memRead  <= 1'b0;
                    exe_memWrite <= 1'b0;
                    exe_ctrl     <= '0;
                end
                default: begin
                    exe_valid    <= id_valid;
                    exe_pc       <= id_pc;
                    exe_rs1_data <= id_rs1_data;
                    exe_rs2_data <= id_rs2_data;
                    exe_imm      <= id_imm;
                    exe_rs1_addr <= id_rs1_addr;
                    exe_rs2_addr <= id_rs2_addr;
                    exe_rd_addr  <= id_rd_addr;
                    exe_regWrite <= id_regWrite && id_valid;
                    exe_memRead  <= id_memRead && id_valid;
                    exe_memWrite <= id_memWrite && id_valid;
                    exe_ctrl     <= id_ctrl;
                end
            endcase
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (action == ACT_STALL && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (action == ACT_FLUSH && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: doc/id_exe_hazard_reg.md
Name: id_exe_hazard_reg

Overview:
- ID/EX pipeline register combined with load-use hazard detection and branch-flush control for the 5-stage RV32 core.
- Captures decoded ID-stage operands and control each cycle. Inserts bubbles on load-use hazards and taken branches.
- Drives the EXE-stage rd/regWrite/rs addresses consumed by the forwarding unit.
- Drives PC/IF-ID write enables and saturating hazard performance counters.

Parameters:
- XLEN, 32, datapath width (pc, rs data, imm)
- CTRL_W, 8, width of opaque ALU/branch control bundle passed through
- CNT_W, 16, width of each saturating performance counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_stall  in  1  global freeze from instruction/data memory wait
- id_valid  in  1  ID holds a real instruction (0 = bubble from IF/ID flush)
- id_pc  in  XLEN  ID instruction PC
- id_rs1_addr, id_rs2_addr  in  5 each  ID source register addresses
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  XLEN each  register file read data
- id_imm  in  XLEN  decoded immediate
- id_rd_addr  in  5  destination register
- id_regWrite, id_memRead, id_memWrite  in  1 each  decoded controls
- id_ctrl  in  CTRL_W  ALU/branch control bundle
- exe_branch_taken  in  1  EXE resolved a taken branch/jump (from ALU, combinational)
- exe_valid  out  1  EXE slot holds a real instruction
- exe_pc, exe_rs1_data, exe_rs2_data, exe_imm  out  XLEN each  registered copies
- exe_rs1_addr, exe_rs2_addr, exe_rd_addr  out  5 each  registered addresses (to forwarding unit)
- exe_regWrite, exe_memRead, exe_memWrite  out  1 each  registered controls
- exe_ctrl  out  CTRL_W  registered control bundle
- pc_write  out  1  PC register update enable
- ifid_write  out  1  IF/ID register update enable
- ifid_flush  out  1  IF/ID register load bubble
- load_use  out  1  combinational hazard indication
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (async, rst_n=0): all exe_* outputs, stall_cnt and flush_cnt are 0; exe_valid=0. Registers update only on rising clk once rst_n=1. Reset mid-stall discards the stall.
- load_use = id_valid & exe_valid & exe_memRead & (exe_rd_addr!=0) & ((id_uses_rs1 & id_rs1_addr==exe_rd_addr) | (id_uses_rs2 & id_rs2_addr==exe_rd_addr)).
- Flush condition: flush = exe_valid & exe_branch_taken.
- Per-cycle priority, first match wins:
  1. mem_stall=1:
     - All ID/EX registers hold; counters hold.
     - pc_write=0, ifid_write=0, ifid_flush=0.
     - A pending branch stays in EXE and is acted on the first cycle mem_stall=0.
  2. flush:
     - ID/EX loads a bubble: exe_valid=0, exe_regWrite/memRead/memWrite=0, exe_rd_addr=0; data fields don't-care but set to 0.
     - pc_write=1, ifid_write=1, ifid_flush=1.
     - flush_cnt += 1 (saturating).
     - load_use is ignored because the ID instruction is killed.
  3. load_use:
     - ID/EX loads a bubble (as above); pc_write=0, ifid_write=0, ifid_flush=0.
     - stall_cnt += 1 (saturating).
     - Stall lasts exactly 1 cycle: the bubble clears exe_memRead.
  4. Otherwise:
     - ID/EX captures all id_* fields; exe_valid = id_valid.
     - pc_write=1, ifid_write=1, ifid_flush=0.
- id_valid=0 captured: exe_valid=0 and exe_regWrite/memRead/memWrite are forced to 0 regardless of inputs.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: ID to EXE is 1 cycle. pc_write/ifid_write/ifid_flush/load_use are combinational from the current inputs and exe_* state.

Test Plan:
- Reset: drive rst_n=0 mid-run with exe_memRead=1 loaded -> all exe_* outputs and counters read 0 immediately, before the next clk edge; after release, the first capture sets exe_valid=id_valid.
- Load-use on rs1:
  - Stimulus: EXE holds lw x5 (exe_memRead=1, rd=5); ID holds add x6,x5,x7 with uses_rs1=1.
  - Response: load_use=1, pc_write=0, ifid_write=0. Next cycle: exe_valid=0, exe_regWrite=0, stall_cnt=1.
  - Following cycle: add is captured with exe_rs1_addr=5.
- No false stall:
  - lw x0 followed by add x1,x0,x0 -> load_use=0.
  - lw x5 followed by lui x5 (uses_rs1=0, uses_rs2=0) -> load_use=0.
- Branch plus load-use in the same cycle: exe_branch_taken=1, exe_valid=1, and the load-use match conditions hold simultaneously -> ifid_flush=1, pc_write=1; next exe_valid=0; flush_cnt=1; stall_cnt unchanged.
- mem_stall: hold mem_stall=1 for 3 cycles with exe_branch_taken=1.
  - During the stall: exe_* outputs unchanged, pc_write=0, ifid_flush=0, flush_cnt unchanged.
  - First cycle after release: ifid_flush=1 and flush_cnt increments by 1.
- Saturation: with CNT_W=2, force 5 load-use stalls -> stall_cnt sequence 1,2,3,3,3.
